// File: rtl/alu_seq_decoder.sv
// Registered multi-cycle ALU/shifter control decoder with multiply sequencing.
// Valid/ready on both sides; multiplies wait MUL_LAT cycles, then emit one or two write-back beats.
module alu_seq_decoder #(
    parameter int unsigned MUL_LAT     = 3,
    parameter bit          LONG_MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       alu_op,
    input  logic       s,
    input  logic       branch,
    input  logic       mult,
    input  logic       mul_long,
    input  logic       mul_acc,
    input  logic       mul_signed,
    input  logic [3:0] cmd,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] alu_ctl,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       not_alu,
    output logic       not_shift,
    output logic       swap,
    output logic       inv,
    output logic       mul_start,
    output logic       mul_acc_o,
    output logic       mul_signed_o,
    output logic       wb_hi,
    output logic       undef
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {IDLE, HOLD, MUL_WAIT, MUL_LO, MUL_HI} state_t;

    typedef struct packed {
        logic       out_valid;
        logic [2:0] alu_ctl;
        logic [1:0] flag_w;
        logic       no_write;
        logic       not_alu;
        logic       not_shift;
        logic       swap;
        logic       inv;
        logic       mul_start;
        logic       mul_acc_o;
        logic       mul_signed_o;
        logic       wb_hi;
        logic       undef;
    } ctl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             ctl_q, ctl_d, dec;
    logic             long_q, long_d;
    logic             s_q, s_d;
    logic             accept;
    logic             mul_legal;

    // Flush blocks acceptance so an op presented alongside it is dropped.
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_legal = mult && !(mul_long && !LONG_MUL_EN);

    // Single-beat decode: data-processing, branch/memory, or illegal long multiply.
    always_comb begin
        dec           = '0;
        dec.out_valid = 1'b1;
        if (mult) begin
            dec.undef    = 1'b1;
            dec.no_write = 1'b1;
        end else if (alu_op) begin
            case (cmd)
                4'h4: dec.alu_ctl = 3'b000;
                4'h2: dec.alu_ctl = 3'b001;
                4'h0: dec.alu_ctl = 3'b010;
                4'hC: dec.alu_ctl = 3'b011;
                4'h1: dec.alu_ctl = 3'b110;
                4'h5: dec.alu_ctl = 3'b100;
                4'h6: dec.alu_ctl = 3'b101;
                4'h3: begin dec.alu_ctl = 3'b001; dec.swap = 1'b1; end
                4'h7: begin dec.alu_ctl = 3'b101; dec.swap = 1'b1; end
                4'hE: begin dec.alu_ctl = 3'b010; dec.inv = 1'b1; end
                4'hA: begin dec.alu_ctl = 3'b001; dec.no_write = 1'b1; end
                4'hB: begin dec.alu_ctl = 3'b000; dec.no_write = 1'b1; end
                4'h8: begin dec.alu_ctl = 3'b010; dec.no_write = 1'b1; end
                4'h9: begin dec.alu_ctl = 3'b110; dec.no_write = 1'b1; end
                4'hF: begin dec.not_alu = 1'b1; dec.inv = 1'b1; end
                default: dec.not_alu = 1'b1;
            endcase
            // Carry/overflow are only meaningful for the arithmetic functions.
            dec.flag_w = {s, s & ~dec.alu_ctl[1]};
        end else if (branch && (cmd == 4'b1001) && !s) begin
            dec.not_alu   = 1'b1;
            dec.not_shift = 1'b1;
        end else if (!cmd[2]) begin
            dec.alu_ctl = 3'b001;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ctl_d         = ctl_q;
        ctl_d.mul_start = 1'b0;
        long_d        = long_q;
        s_d           = s_q;

        case (state_q)
            IDLE: ;
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ctl_d   = '0;
                end
            end
            MUL_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d         = MUL_LO;
                    cnt_d           = '0;
                    ctl_d.out_valid = 1'b1;
                    ctl_d.wb_hi     = 1'b0;
                    ctl_d.flag_w    = long_q ? 2'b00 : {s_q, 1'b0};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MUL_LO: begin
                if (out_ready) begin
                    if (long_q) begin
                        state_d      = MUL_HI;
                        ctl_d.wb_hi  = 1'b1;
                        ctl_d.flag_w = {s_q, 1'b0};
                    end else begin
                        state_d = IDLE;
                        ctl_d   = '0;
                    end
                end
            end
            MUL_HI: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ctl_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ctl_d   = '0;
            end
        endcase

        if (accept) begin
            if (mul_legal) begin
                state_d            = MUL_WAIT;
                cnt_d              = '0;
                ctl_d              = '0;
                ctl_d.mul_start    = 1'b1;
                ctl_d.mul_acc_o    = mul_acc;
                ctl_d.mul_signed_o = mul_signed;
                long_d             = mul_long && LONG_MUL_EN;
                s_d                = s;
            end else begin
                state_d = HOLD;
                ctl_d   = dec;
            end
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctl_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
            long_q  <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            long_q  <= long_d;
            s_q     <= s_d;
        end
    end

    assign out_valid    = ctl_q.out_valid;
    assign alu_ctl      = ctl_q.alu_ctl;
    assign flag_w       = ctl_q.flag_w;
    assign no_write     = ctl_q.no_write;
    assign not_alu      = ctl_q.not_alu;
    assign not_shift    = ctl_q.not_shift;
    assign swap         = ctl_q.swap;
    assign inv          = ctl_q.inv;
    assign mul_start    = ctl_q.mul_start;
    assign mul_acc_o    = ctl_q.mul_acc_o;
    assign mul_signed_o = ctl_q.mul_signed_o;
    assign wb_hi        = ctl_q.wb_hi;
    assign undef        = ctl_q.undef;

endmodule

// File: tb/tb_alu_seq_decoder.sv
// Directed bench: decode vector table plus hand-written multiply, flush and reset sequences.
module tb_alu_seq_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic       alu_op = 1'b0, s = 1'b0, branch = 1'b0, mult = 1'b0;
    logic       mul_long = 1'b0, mul_acc = 1'b0, mul_signed = 1'b0;
    logic [3:0] cmd = 4'h0;

    logic       in_ready0, out_valid0, no_write0, not_alu0, not_shift0, swap0, inv0;
    logic       mul_start0, mul_acc_o0, mul_signed_o0, wb_hi0, undef0;
    logic [2:0] alu_ctl0;
    logic [1:0] flag_w0;
    logic       in_ready1, out_valid1, no_write1, not_alu1, not_shift1, swap1, inv1;
    logic       mul_start1, mul_acc_o1, mul_signed_o1, wb_hi1, undef1;
    logic [2:0] alu_ctl1;
    logic [1:0] flag_w1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_decoder #(.MUL_LAT(3), .LONG_MUL_EN(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_op(alu_op), .s(s), .branch(branch), .mult(mult), .mul_long(mul_long),
        .mul_acc(mul_acc), .mul_signed(mul_signed), .cmd(cmd), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .alu_ctl(alu_ctl0), .flag_w(flag_w0),
        .no_write(no_write0), .not_alu(not_alu0), .not_shift(not_shift0), .swap(swap0),
        .inv(inv0), .mul_start(mul_start0), .mul_acc_o(mul_acc_o0),
        .mul_signed_o(mul_signed_o0), .wb_hi(wb_hi0), .undef(undef0)
    );

    alu_seq_decoder #(.MUL_LAT(1), .LONG_MUL_EN(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .alu_op(alu_op), .s(s), .branch(branch), .mult(mult), .mul_long(mul_long),
        .mul_acc(mul_acc), .mul_signed(mul_signed), .cmd(cmd), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .alu_ctl(alu_ctl1), .flag_w(flag_w1),
        .no_write(no_write1), .not_alu(not_alu1), .not_shift(not_shift1), .swap(swap1),
        .inv(inv1), .mul_start(mul_start1), .mul_acc_o(mul_acc_o1),
        .mul_signed_o(mul_signed_o1), .wb_hi(wb_hi1), .undef(undef1)
    );

    // {alu_ctl, flag_w, no_write, not_alu, not_shift, swap, inv}
    logic [9:0] obs0;
    assign obs0 = {alu_ctl0, flag_w0, no_write0, not_alu0, not_shift0, swap0, inv0};

    typedef struct {
        logic       alu_op;
        logic       s;
        logic       branch;
        logic [3:0] cmd;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[21];
    int   nv = 0;

    function automatic logic [9:0] mk(input logic [2:0] c, input logic [1:0] f, input logic nw,
                                      input logic na, input logic ns, input logic sw, input logic iv);
        return {c, f, nw, na, ns, sw, iv};
    endfunction

    task automatic add(input logic a, input logic sb, input logic b, input logic [3:0] c,
                       input logic [9:0] e);
        vecs[nv] = '{alu_op: a, s: sb, branch: b, cmd: c, exp: e};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_op(input logic a, input logic sb, input logic b, input logic m,
                          input logic ml, input logic ma, input logic ms, input logic [3:0] c);
        alu_op = a; s = sb; branch = b; mult = m;
        mul_long = ml; mul_acc = ma; mul_signed = ms; cmd = c;
        in_valid = 1'b1;
    endtask

    task automatic clr_op();
        in_valid = 1'b0; alu_op = 1'b0; s = 1'b0; branch = 1'b0; mult = 1'b0;
        mul_long = 1'b0; mul_acc = 1'b0; mul_signed = 1'b0; cmd = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int quiet;

        add(1, 1, 0, 4'h2, mk(3'b001, 2'b11, 0, 0, 0, 0, 0));
        add(1, 0, 0, 4'h4, mk(3'b000, 2'b00, 0, 0, 0, 0, 0));
        add(1, 1, 0, 4'h0, mk(3'b010, 2'b10, 0, 0, 0, 0, 0));
        add(1, 1, 0, 4'hC, mk(3'b011, 2'b10, 0, 0, 0, 0, 0));
        add(1, 1, 0, 4'h1, mk(3'b110, 2'b10, 0, 0, 0, 0, 0));
        add(1, 1, 0, 4'h5, mk(3'b100, 2'b11, 0, 0, 0, 0, 0));
        add(1, 0, 0, 4'h6, mk(3'b101, 2'b00, 0, 0, 0, 0, 0));
        add(1, 1, 0, 4'h3, mk(3'b001, 2'b11, 0, 0, 0, 1, 0));
        add(1, 1, 0, 4'h7, mk(3'b101, 2'b11, 0, 0, 0, 1, 0));
        add(1, 1, 0, 4'hE, mk(3'b010, 2'b10, 0, 0, 0, 0, 1));
        add(1, 1, 0, 4'hA, mk(3'b001, 2'b11, 1, 0, 0, 0, 0));
        add(1, 1, 0, 4'hB, mk(3'b000, 2'b11, 1, 0, 0, 0, 0));
        add(1, 1, 0, 4'h8, mk(3'b010, 2'b10, 1, 0, 0, 0, 0));
        add(1, 1, 0, 4'h9, mk(3'b110, 2'b10, 1, 0, 0, 0, 0));
        add(1, 1, 0, 4'hF, mk(3'b000, 2'b11, 0, 1, 0, 0, 1));
        add(1, 0, 0, 4'hD, mk(3'b000, 2'b00, 0, 1, 0, 0, 0));
        add(0, 0, 1, 4'h9, mk(3'b000, 2'b00, 0, 1, 1, 0, 0));
        add(0, 1, 1, 4'h9, mk(3'b001, 2'b00, 0, 0, 0, 0, 0));
        add(0, 0, 0, 4'h3, mk(3'b001, 2'b00, 0, 0, 0, 0, 0));
        add(0, 0, 0, 4'h6, mk(3'b000, 2'b00, 0, 0, 0, 0, 0));
        add(1, 0, 1, 4'h9, mk(3'b110, 2'b00, 1, 0, 0, 0, 0));

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_outs", 32'({out_valid0, obs0, mul_start0, mul_acc_o0, mul_signed_o0, wb_hi0, undef0}), 32'd0);
        reset = 1'b0;

        // Single-op decode table, latency 1, drained immediately
        out_ready = 1'b1;
        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            set_op(vecs[i].alu_op, vecs[i].s, vecs[i].branch, 0, 0, 0, 0, vecs[i].cmd);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid0), 32'd1);
            chk($sformatf("vec%0d_ctl", i), 32'(obs0), 32'(vecs[i].exp));
            clr_op();
        end

        // Back-to-back ADD, CMP, BX through HOLD accept-on-drain
        do_reset();
        set_op(1, 0, 0, 0, 0, 0, 0, 4'h4);
        @(negedge clk);
        chk("b2b_add", 32'({out_valid0, obs0}), 32'({1'b1, mk(3'b000, 2'b00, 0, 0, 0, 0, 0)}));
        set_op(1, 1, 0, 0, 0, 0, 0, 4'hA);
        #1 chk("b2b_hold_ready", 32'(in_ready0), 32'd1);
        @(negedge clk);
        chk("b2b_cmp", 32'({out_valid0, obs0}), 32'({1'b1, mk(3'b001, 2'b11, 1, 0, 0, 0, 0)}));
        set_op(0, 0, 1, 0, 0, 0, 0, 4'h9);
        @(negedge clk);
        chk("b2b_bx", 32'({out_valid0, obs0}), 32'({1'b1, mk(3'b000, 2'b00, 0, 1, 1, 0, 0)}));
        clr_op();
        out_ready = 1'b0;
        #1 chk("hold_stall_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("hold_stall_beat", 32'({out_valid0, obs0}), 32'({1'b1, mk(3'b000, 2'b00, 0, 1, 1, 0, 0)}));
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_drain", 32'({out_valid0, in_ready0}), 32'b01);

        // Short multiply, MUL_LAT=3
        do_reset();
        set_op(0, 1, 0, 1, 0, 1, 0, 4'h0);
        @(negedge clk);
        clr_op();
        chk("mul_w1", 32'({mul_start0, in_ready0, out_valid0, mul_acc_o0}), 32'b1001);
        @(negedge clk);
        chk("mul_w2", 32'({mul_start0, in_ready0, out_valid0}), 32'b000);
        @(negedge clk);
        chk("mul_w3", 32'({mul_start0, in_ready0, out_valid0}), 32'b000);
        @(negedge clk);
        chk("mul_beat", 32'({out_valid0, wb_hi0, flag_w0, alu_ctl0, not_alu0, not_shift0, mul_acc_o0}),
            32'({1'b1, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1}));
        chk("mul_beat_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("mul_done", 32'({out_valid0, in_ready0}), 32'b01);

        // UMULL with LO stalled two cycles
        do_reset();
        out_ready = 1'b0;
        set_op(0, 1, 0, 1, 1, 0, 0, 4'h0);
        @(negedge clk);
        clr_op();
        repeat (3) @(negedge clk);
        chk("umull_lo", 32'({out_valid0, wb_hi0, flag_w0}), 32'b1000);
        @(negedge clk);
        chk("umull_lo_held", 32'({out_valid0, wb_hi0, flag_w0}), 32'b1000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("umull_hi", 32'({out_valid0, wb_hi0, flag_w0}), 32'b1110);
        @(negedge clk);
        chk("umull_done", 32'({out_valid0, wb_hi0, in_ready0}), 32'b001);

        // Flush in the second wait cycle
        do_reset();
        set_op(0, 1, 0, 1, 0, 0, 0, 4'h0);
        @(negedge clk);
        clr_op();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_idle", 32'({out_valid0, mul_start0, in_ready0}), 32'b001);
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid0 !== 1'b0) quiet = 0;
        end
        chk("flush_no_beat", 32'(quiet), 32'd1);
        set_op(1, 0, 0, 0, 0, 0, 0, 4'h4);
        flush = 1'b1;
        #1 chk("flush_blocks_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("flush_not_accepted", 32'(out_valid0), 32'd0);
        flush = 1'b0;
        clr_op();

        // SMLAL, reset during HI beat
        do_reset();
        set_op(0, 1, 0, 1, 1, 1, 1, 4'h0);
        @(negedge clk);
        clr_op();
        repeat (3) @(negedge clk);
        chk("smlal_lo", 32'({out_valid0, wb_hi0, flag_w0, mul_acc_o0, mul_signed_o0}), 32'b100011);
        @(negedge clk);
        chk("smlal_hi", 32'({out_valid0, wb_hi0, flag_w0, mul_acc_o0, mul_signed_o0}), 32'b111011);
        reset = 1'b1;
        #1 chk("rst_mid_hi", 32'({out_valid0, wb_hi0, in_ready0, mul_acc_o0}), 32'b0010);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_after", 32'({out_valid0, in_ready0}), 32'b01);

        // LONG_MUL_EN=0 instance: long multiply is a single undef beat
        do_reset();
        out_ready = 1'b0;
        set_op(0, 1, 0, 1, 1, 0, 0, 4'h0);
        @(negedge clk);
        clr_op();
        chk("undef_beat", 32'({out_valid1, undef1, no_write1, flag_w1, mul_start1, wb_hi1}), 32'b1110000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("undef_done", 32'({out_valid1, mul_start1, in_ready1}), 32'b001);

        // MUL_LAT=1 instance: one wait cycle
        do_reset();
        set_op(0, 1, 0, 1, 0, 0, 0, 4'h0);
        @(negedge clk);
        clr_op();
        chk("lat1_wait", 32'({mul_start1, out_valid1, in_ready1}), 32'b100);
        @(negedge clk);
        chk("lat1_beat", 32'({out_valid1, mul_start1, flag_w1, wb_hi1}), 32'b10100);
        @(negedge clk);
        chk("lat1_done", 32'({out_valid1, in_ready1}), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
